mac_tx_sched: RTL and testbench

MAC_TX_SCHED -- requirements
Module: mac_tx_sched

---
 rtl/eth_pkg.sv | 18 +
 rtl/eth_crc32.sv | 18 +
 rtl/mac_tx_sched.sv | 145 ++++++++++++++
 tb/tb_mac_tx_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet MAC constants, transmit FSM encoding and CRC-32 byte step
package eth_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IPG} tx_state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [10:0] PREAMBLE_LEN = 11'd7;
  localparam logic [10:0] MIN_FRAME = 11'd60;
  localparam logic [10:0] MAX_FRAME = 11'd1514;
  localparam logic [10:0] IPG_BYTES = 11'd12;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC_POLY : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: byte-wide reflected CRC-32 accumulator shared by transmit and receive FCS logic
//   clk, rst : clock, async active-high reset (state returns to CRC_INIT)
//   clr, en  : restart accumulation / fold byte d into the state
//   crc      : running CRC state (uncomplemented)
import eth_pkg::*;
module eth_crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en) crc <= crc32_byte(crc, d);
endmodule

// File: rtl/mac_tx_sched.sv
// mac_tx_sched: two-requester round-robin Ethernet transmit scheduler with preamble, pad, FCS and IPG
//   in_txc, in_rst            : byte clock, async active-high reset
//   in_crs                    : carrier sense, defers frame start
//   in_reqN_valid/data/last   : requester N byte stream (DA..payload), out_reqN_ready handshake
//   out_gnt                   : one-hot current grant
//   out_txen/out_txd/out_txer : PHY byte interface
//   out_busy                  : FSM not idle
import eth_pkg::*;
module mac_tx_sched (
  input  logic       in_txc,
  input  logic       in_rst,
  input  logic       in_crs,
  input  logic       in_req0_valid,
  input  logic [7:0] in_req0_data,
  input  logic       in_req0_last,
  output logic       out_req0_ready,
  input  logic       in_req1_valid,
  input  logic [7:0] in_req1_data,
  input  logic       in_req1_last,
  output logic       out_req1_ready,
  output logic [1:0] out_gnt,
  output logic       out_txen,
  output logic [7:0] out_txd,
  output logic       out_txer,
  output logic       out_busy
);
  tx_state_t state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [1:0] gnt_n;
  logic [7:0] txd_n, sel_data, crc_d;
  logic [31:0] crc, fcs;
  logic pref1, pref1_n, crs_q, txen_n, txer_n, crc_clr, crc_en, win1, at_max, sel_valid, sel_last;
  // The FSM runs one byte ahead of the PHY: each state computes the byte
  // registered onto out_txd for the following cycle.
  assign at_max = cnt == MAX_FRAME;
  assign sel_valid = |(out_gnt & {in_req1_valid, in_req0_valid});
  assign sel_last = |(out_gnt & {in_req1_last, in_req0_last});
  assign sel_data = out_gnt[1] ? in_req1_data : in_req0_data;
  assign win1 = in_req1_valid && (!in_req0_valid || pref1);
  assign fcs = ~crc;
  assign crc_d = state == S_PAD ? 8'h00 : sel_data;
  assign out_req0_ready = state == S_DATA && !at_max && out_gnt[0];
  assign out_req1_ready = state == S_DATA && !at_max && out_gnt[1];
  assign out_busy = state != S_IDLE;
  eth_crc32 u_crc (.clk(in_txc), .rst(in_rst), .clr(crc_clr), .en(crc_en), .d(crc_d), .crc(crc));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    gnt_n = out_gnt;
    pref1_n = pref1;
    txen_n = 1'b0;
    txd_n = 8'h00;
    txer_n = 1'b0;
    crc_clr = 1'b0;
    crc_en = 1'b0;
    case (state)
      S_IDLE: if (!crs_q && (in_req0_valid || in_req1_valid)) begin
        state_n = S_PREAMBLE;
        cnt_n = 11'd1;
        gnt_n = win1 ? 2'b10 : 2'b01;
        pref1_n = !win1;
        txen_n = 1'b1;
        txd_n = PREAMBLE_BYTE;
        crc_clr = 1'b1;
      end
      S_PREAMBLE: begin
        txen_n = 1'b1;
        txd_n = PREAMBLE_BYTE;
        cnt_n = cnt + 11'd1;
        state_n = cnt == PREAMBLE_LEN - 11'd1 ? S_SFD : S_PREAMBLE;
      end
      S_SFD: begin
        txen_n = 1'b1;
        txd_n = SFD_BYTE;
        cnt_n = '0;
        state_n = S_DATA;
      end
      S_DATA: begin
        txen_n = 1'b1;
        if (at_max || !sel_valid) begin
          // abort: flag the error on the byte slot still under txen, then go quiet
          txer_n = 1'b1;
          state_n = S_IPG;
          cnt_n = '0;
        end else begin
          txd_n = sel_data;
          crc_en = 1'b1;
          cnt_n = cnt + 11'd1;
          if (sel_last) begin
            state_n = cnt_n < MIN_FRAME ? S_PAD : S_FCS;
            cnt_n = cnt_n < MIN_FRAME ? cnt_n : '0;
          end
        end
      end
      S_PAD: begin
        txen_n = 1'b1;
        crc_en = 1'b1;
        cnt_n = cnt + 11'd1;
        if (cnt_n == MIN_FRAME) begin
          state_n = S_FCS;
          cnt_n = '0;
        end
      end
      S_FCS: begin
        txen_n = 1'b1;
        txd_n = fcs[{cnt[1:0], 3'b000} +: 8];
        cnt_n = cnt + 11'd1;
        if (cnt == 11'd3) begin
          state_n = S_IPG;
          cnt_n = '0;
        end
      end
      S_IPG: begin
        // first IPG cycle overlaps the final byte on the wire, so count IPG_BYTES+1
        cnt_n = cnt + 11'd1;
        if (cnt == IPG_BYTES) begin
          state_n = S_IDLE;
          cnt_n = '0;
          gnt_n = 2'b00;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge in_txc or posedge in_rst)
    if (in_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      out_gnt <= 2'b00;
      pref1 <= 1'b0;
      crs_q <= 1'b1;
      out_txen <= 1'b0;
      out_txd <= 8'h00;
      out_txer <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_gnt <= gnt_n;
      pref1 <= pref1_n;
      crs_q <= in_crs;
      out_txen <= txen_n;
      out_txd <= txd_n;
      out_txer <= txer_n;
    end
endmodule

// File: tb/tb_mac_tx_sched.sv
// tb_mac_tx_sched: directed and randomized frame checks of mac_tx_sched against a byte-stream model
module tb_mac_tx_sched;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst = 1'b1, crs = 1'b0;
  logic v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic r0, r1, txen, txer, busy;
  logic [1:0] gnt;
  logic [7:0] txd;
  int passed = 0, failed = 0, total = 0;
  logic [7:0] bq0[$], bq1[$];
  bit lq0[$], lq1[$];
  bit t_en[$], t_er[$], t_b[$], t_c[$];
  logic [7:0] t_d[$];
  logic [1:0] t_g[$];
  int rs[$], re[$];

  always #5 clk = ~clk;

  mac_tx_sched dut (
    .in_txc(clk), .in_rst(rst), .in_crs(crs),
    .in_req0_valid(v0), .in_req0_data(d0), .in_req0_last(l0), .out_req0_ready(r0),
    .in_req1_valid(v1), .in_req1_data(d1), .in_req1_last(l1), .out_req1_ready(r1),
    .out_gnt(gnt), .out_txen(txen), .out_txd(txd), .out_txer(txer), .out_busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input bq_t p);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (p[i])
      for (int b = 0; b < 8; b++) begin
        bit fb = c[0] ^ p[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  // Expected PHY byte stream for one good frame: preamble, SFD, payload padded to 60, FCS LSB first.
  function automatic bq_t wire_bytes(input bq_t p);
    bq_t e, body;
    logic [31:0] c;
    body = p;
    while (body.size() < 60) body.push_back(8'h00);
    c = ~ref_crc(body);
    repeat (7) e.push_back(8'h55);
    e.push_back(8'hD5);
    foreach (body[i]) e.push_back(body[i]);
    for (int i = 0; i < 4; i++) e.push_back(c[8*i +: 8]);
    return e;
  endfunction

  task automatic drive();
    v0 = bq0.size() != 0;
    d0 = v0 ? bq0[0] : 8'h00;
    l0 = v0 ? lq0[0] : 1'b0;
    v1 = bq1.size() != 0;
    d1 = v1 ? bq1[0] : 8'h00;
    l1 = v1 ? lq1[0] : 1'b0;
  endtask

  task automatic tick();
    bit a0, a1;
    @(negedge clk);
    t_en.push_back(txen); t_d.push_back(txd); t_er.push_back(txer);
    t_g.push_back(gnt); t_b.push_back(busy); t_c.push_back(crs);
    chk("invariant", {31'd0, (!txen && txd != 8'h00) || (r0 && !gnt[0]) || (r1 && !gnt[1])}, 0);
    a0 = v0 && r0;
    a1 = v1 && r1;
    @(posedge clk);
    #1;
    if (a0) begin void'(bq0.pop_front()); void'(lq0.pop_front()); end
    if (a1) begin void'(bq1.pop_front()); void'(lq1.pop_front()); end
    drive();
  endtask

  task automatic clear_logs();
    t_en.delete(); t_d.delete(); t_er.delete(); t_g.delete(); t_b.delete(); t_c.delete();
  endtask

  task automatic enq(input int r, input int n, input bit lst, output bq_t f);
    f.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b = 8'($urandom);
      f.push_back(b);
      if (r == 0) begin bq0.push_back(b); lq0.push_back(lst && i == n - 1); end
      else begin bq1.push_back(b); lq1.push_back(lst && i == n - 1); end
    end
    drive();
  endtask

  task automatic run_quiet(input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((t_b[$] || bq0.size() != 0 || bq1.size() != 0) && k < budget);
    chk("quiet", {31'd0, t_b[$] || bq0.size() != 0 || bq1.size() != 0}, 0);
  endtask

  task automatic find_runs();
    rs.delete(); re.delete();
    for (int k = 0; k < t_en.size(); k++) begin
      if (t_en[k] && (k == 0 || !t_en[k-1])) rs.push_back(k);
      if (t_en[k] && (k == t_en.size() - 1 || !t_en[k+1])) re.push_back(k + 1);
    end
  endtask

  task automatic cmp_run(input string tag, input int idx, input bq_t e, input int len, input logic [1:0] g, input int er);
    int bad = 0, ers = 0;
    chk({tag, " len"}, re[idx] - rs[idx], len);
    for (int i = 0; i < e.size() && i < re[idx] - rs[idx]; i++) if (t_d[rs[idx] + i] !== e[i]) bad++;
    for (int i = rs[idx]; i < re[idx]; i++) ers += int'(t_er[i]);
    chk({tag, " bytes"}, bad, 0);
    chk({tag, " txer"}, ers, er);
    chk({tag, " gnt"}, t_g[rs[idx]], g);
  endtask

  // Low-txen cycles while busy after a frame: the inter-packet gap.
  function automatic int gap(input int idx);
    int n = 0;
    for (int k = re[idx]; k < t_b.size() && t_b[k]; k++) if (!t_en[k]) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bq0.delete(); lq0.delete(); bq1.delete(); lq1.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    bq_t f, g, h, e;
    int n, fall;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst txen", txen, 0); chk("rst txd", txd, 0); chk("rst txer", txer, 0);
    chk("rst gnt", gnt, 0); chk("rst busy", busy, 0); chk("rst r0", r0, 0); chk("rst r1", r1, 0);
    rst = 1'b0;
    clear_logs();

    // 64-byte frame from requester 0: no pad, full preamble/FCS, 12-cycle gap
    enq(0, 64, 1'b1, f);
    run_quiet(400);
    find_runs();
    chk("t1 runs", rs.size(), 1);
    if (rs.size() > 0 && rs[0] > 0) begin
      cmp_run("t1", 0, wire_bytes(f), 76, 2'b01, 0);
      chk("t1 ipg", gap(0), 12);
      chk("t1 idle before", t_b[rs[0] - 1], 0);
    end
    n = 0;
    foreach (t_er[i]) n += int'(t_er[i]);
    chk("t1 txer total", n, 0);
    chk("t1 gnt idle", t_g[$], 0);

    // 20-byte frame from requester 1: padded to 60
    clear_logs();
    enq(1, 20, 1'b1, f);
    run_quiet(300);
    find_runs();
    chk("t2 runs", rs.size(), 1);
    if (rs.size() > 0) cmp_run("t2", 0, wire_bytes(f), 72, 2'b10, 0);
    n = 0;
    foreach (t_en[i]) n += int'(t_en[i]);
    chk("t2 txen cycles", n, 72);

    // tie after reset: req0, then req1, then req0's second frame wins nothing until req1 served
    do_reset();
    enq(0, 10, 1'b1, f);
    enq(0, 15, 1'b1, h);
    enq(1, 62, 1'b1, g);
    run_quiet(1000);
    find_runs();
    chk("t3 runs", rs.size(), 3);
    if (rs.size() == 3) begin
      cmp_run("t3 a", 0, wire_bytes(f), 72, 2'b01, 0);
      cmp_run("t3 b", 1, wire_bytes(g), 74, 2'b10, 0);
      cmp_run("t3 c", 2, wire_bytes(h), 72, 2'b01, 0);
      // 12 IPG cycles plus the one IDLE arbitration cycle
      chk("t3 gap ab", rs[1] - re[0], 13);
      chk("t3 gap bc", rs[2] - re[1], 13);
    end

    // carrier sense deferral
    crs = 1'b1;
    repeat (2) tick();
    clear_logs();
    enq(0, 25, 1'b1, f);
    repeat (30) tick();
    find_runs();
    chk("t4 deferred", rs.size(), 0);
    crs = 1'b0;
    run_quiet(400);
    find_runs();
    fall = 0;
    while (fall < t_c.size() && t_c[fall]) fall++;
    chk("t4 runs", rs.size(), 1);
    if (rs.size() > 0) begin
      chk("t4 start", rs[0], fall + 2);
      cmp_run("t4", 0, wire_bytes(f), 72, 2'b01, 0);
    end

    // underrun after 30 bytes
    clear_logs();
    enq(0, 30, 1'b0, f);
    run_quiet(300);
    find_runs();
    e.delete();
    repeat (7) e.push_back(8'h55);
    e.push_back(8'hD5);
    foreach (f[i]) e.push_back(f[i]);
    chk("t5 runs", rs.size(), 1);
    if (rs.size() > 0) begin
      cmp_run("t5", 0, e, 39, 2'b01, 1);
      chk("t5 txer at end", t_er[re[0] - 1], 1);
      chk("t5 ipg", gap(0), 12);
    end
    chk("t5 gnt idle", t_g[$], 0);

    // max frame length without last: byte 1515 must be held, not consumed
    clear_logs();
    enq(0, 1515, 1'b0, f);
    n = 0;
    do begin
      tick();
      n++;
    end while (!t_er[$] && n < 2000);
    chk("t6 txer seen", t_er[$], 1);
    chk("t6 held", bq0.size(), 1);
    bq0.delete(); lq0.delete();
    drive();
    run_quiet(100);
    find_runs();
    e.delete();
    repeat (7) e.push_back(8'h55);
    e.push_back(8'hD5);
    for (int i = 0; i < 1514; i++) e.push_back(f[i]);
    chk("t6 runs", rs.size(), 1);
    if (rs.size() > 0) begin
      cmp_run("t6", 0, e, 1523, 2'b01, 1);
      chk("t6 ipg", gap(0), 12);
    end

    // random frames on random requesters, order from round-robin model
    do_reset();
    begin
      logic [7:0] flat[$];
      int fofs[$], flen[$], o0[$], o1[$];
      bit lg = 1'b1;
      for (int i = 0; i < 5; i++) begin
        int r = int'($urandom_range(0, 1));
        int ln = int'($urandom_range(1, 80));
        enq(r, ln, 1'b1, f);
        fofs.push_back(flat.size());
        flen.push_back(ln);
        foreach (f[j]) flat.push_back(f[j]);
        if (r == 0) o0.push_back(i); else o1.push_back(i);
      end
      run_quiet(2000);
      find_runs();
      chk("t7 runs", rs.size(), 5);
      for (int j = 0; j < 5; j++) begin
        bit pick;
        int id;
        pick = (o0.size() != 0 && o1.size() != 0) ? !lg : o1.size() != 0;
        id = pick ? o1.pop_front() : o0.pop_front();
        lg = pick;
        if (j < rs.size())
          cmp_run("t7", j, wire_bytes(flat[fofs[id] : fofs[id] + flen[id] - 1]),
                  (flen[id] < 60 ? 60 : flen[id]) + 12, pick ? 2'b10 : 2'b01, 0);
      end
    end

    // reset during FCS byte 2, then a fresh frame
    clear_logs();
    enq(1, 60, 1'b1, f);
    e = wire_bytes(f);
    n = 0;
    for (int k = 0; k < 500 && n < 70; k++) begin
      tick();
      if (t_en[$]) n++;
    end
    chk("t8 reach", n, 70);
    chk("t8 fcs2", txd, e[70]);
    rst = 1'b1;
    #1;
    chk("t8 txen", txen, 0); chk("t8 gnt", gnt, 0); chk("t8 busy", busy, 0);
    chk("t8 txd", txd, 0); chk("t8 r1", r1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    enq(0, 61, 1'b1, g);
    run_quiet(300);
    find_runs();
    chk("t8 runs", rs.size(), 1);
    if (rs.size() > 0) cmp_run("t8", 0, wire_bytes(g), 73, 2'b01, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
